// File: rtl/adder_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
//   Shared types and helpers for the shared-adder arbiter.
//   - state_t        : control FSM states (IDLE -> CALC -> RESP)
//   - DATA_W_DEFAULT : default operand / sum width
//   - MAX_REQ        : largest supported requester count
//   - rr_pick()      : round-robin winner selection
// ---------------------------------------------------------------------------
package adder_arb_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int MAX_REQ        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns the first requester with valid set, scanning ptr, ptr+1, ...
    // modulo n.  valid is zero-extended to MAX_REQ bits by the caller.
    // The result is only meaningful when at least one valid bit is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int ptr,
                                   input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (ptr + k) % n;
            if ((k < n) && !found && valid[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// adder_arbiter_if
//   Request and response channels of the shared adder.
//   req_valid/req_ready : per-requester handshake (one bit per requester)
//   req_a/req_b         : packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_sum/rsp_carry : owner id, sum and carry of the result
//   modport master : requesters / result consumer side
//   modport slave  : the arbiter
// ---------------------------------------------------------------------------
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_carry;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

endinterface

// File: rtl/adder_arbiter_add_unit.sv
// ---------------------------------------------------------------------------
// add_unit
//   Registered DATA_W-bit adder with carry out.
//   clk, reset_n : clock, asynchronous active-low clear
//   en           : load {carry,sum} <= a + b on this edge
//   a, b         : operands
//   sum, carry   : registered result, held while en is low
// ---------------------------------------------------------------------------
module add_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W-1:0] sum_reg;
    logic              carry_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (en) begin
            {carry_reg, sum_reg} <= {1'b0, a} + {1'b0, b};
        end
    end

    assign sum   = sum_reg;
    assign carry = carry_reg;

endmodule

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Shares one registered adder between NUM_REQ requesters.  A round-robin
//   arbiter grants one requester while idle, latches its operands, runs the
//   adder for one cycle and presents the result until it is accepted.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : adder_arbiter_if slave (request and response channels)
// ---------------------------------------------------------------------------
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    adder_arbiter_if.slave bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              rsp_valid_reg;

    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic [MAX_REQ-1:0] valid_ext;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic [DATA_W-1:0] add_sum;
    logic              add_carry;

    // Unpack the per-requester operand slices.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi] = bus.req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = bus.req_valid;
    end

    assign any_valid = |bus.req_valid;
    assign winner    = ID_W'(rr_pick(valid_ext, int'(rr_ptr_reg), NUM_REQ));

    // Grant is combinational and only offered while idle.  Gating with
    // reset_n keeps every output low for the whole reset pulse.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = reset_n && (state_reg == IDLE) &&
                                       any_valid && (winner == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Any valid request is granted this cycle, so a
                    // transfer always happens when any_valid is high.
                    if (any_valid) begin
                        a_reg     <= a_arr[winner];
                        b_reg     <= b_arr[winner];
                        id_reg    <= winner;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                        // Priority moves to the requester after the one served.
                        rr_ptr_reg    <= (id_reg == ID_W'(NUM_REQ - 1)) ?
                                         '0 : id_reg + ID_W'(1);
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    add_unit #(
        .DATA_W (DATA_W)
    ) u_add (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_reg == CALC),
        .a       (a_reg),
        .b       (b_reg),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_sum   = add_sum;
    assign bus.rsp_carry = add_carry;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    logic clk = 1'b0;
    logic reset_n;

    adder_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    adder_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int id;
        int sum;
        int carry;
    } exp_t;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        int         sum;
        int         carry;
    } vec_t;

    exp_t exp_q[$];
    int   grant_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: expected results pushed on request handshakes, popped
    // and compared on response handshakes.  Sampled on the falling edge,
    // so the handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (bus.req_valid != 4'b0)
                check("ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_t e;
                    int   s;
                    s       = int'(bus.req_a[i*8 +: 8]) + int'(bus.req_b[i*8 +: 8]);
                    e.id    = i;
                    e.sum   = s % 256;
                    e.carry = s / 256;
                    exp_q.push_back(e);
                    grant_q.push_back(i);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_id", int'(bus.rsp_id), e.id);
                    check("sb_sum", int'(bus.rsp_sum), e.sum);
                    check("sb_carry", int'(bus.rsp_carry), e.carry);
                end
                $display("[TB] rsp id=%0d sum=%0d carry=%0d", bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
            end
        end
    end

    // Raise req_valid[id] and wait (bounded) for the grant; returns one
    // step after the transferring edge with the request withdrawn.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.req_a[id*8 +: 8] = a;
        bus.req_b[id*8 +: 8] = b;
        bus.req_valid[id]    = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        $display("[TB] req id=%0d a=%0d b=%0d granted=%0d", id, a, b, ok);
    endtask

    // Called one step after the request edge; lat counts edges until
    // rsp_valid is seen.  Returns on the falling edge with rsp_valid high.
    task automatic wait_rsp(output int lat);
        logic got;
        got = 1'b0;
        lat = 1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!got) check("rsp_timeout", 0, 1);
    endtask

    task automatic send_one(input int id, input logic [7:0] a, input logic [7:0] b,
                            output int rid, output int rsum, output int rcarry,
                            output int lat);
        issue(id, a, b);
        wait_rsp(lat);
        rid    = int'(bus.rsp_id);
        rsum   = int'(bus.rsp_sum);
        rcarry = int'(bus.rsp_carry);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   rid, rsum, rcarry, lat;
        int   exp_order[5];

        vecs[0] = '{id: 0, a: 8'd200, b: 8'd100, sum: 44,  carry: 1};
        vecs[1] = '{id: 1, a: 8'd255, b: 8'd1,   sum: 0,   carry: 1};
        vecs[2] = '{id: 2, a: 8'd0,   b: 8'd0,   sum: 0,   carry: 0};
        vecs[3] = '{id: 2, a: 8'd255, b: 8'd255, sum: 254, carry: 1};
        vecs[4] = '{id: 1, a: 8'd4,   b: 8'd7,   sum: 11,  carry: 0};
        vecs[5] = '{id: 3, a: 8'd128, b: 8'd127, sum: 255, carry: 0};
        exp_order = '{0, 1, 2, 3, 0};

        // ---- Reset state (requests pending must not see a grant) ----
        reset_n       = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_rsp_valid", int'(bus.rsp_valid), 0);
            check("rst_req_ready", int'(bus.req_ready), 0);
            check("rst_rsp_sum", int'(bus.rsp_sum), 0);
            check("rst_rsp_id", int'(bus.rsp_id), 0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 4'h0;
        reset_n       = 1'b1;
        cycles(1);

        // ---- Latency: rsp_valid two edges after the request handshake ----
        send_one(0, 8'd8, 8'd17, rid, rsum, rcarry, lat);
        check("lat_cycles", lat, 2);
        check("lat_sum", rsum, 25);
        check("lat_id", rid, 0);

        // ---- Table-driven single transactions (incl. wrap cases) ----
        for (int v = 0; v < 6; v++) begin
            send_one(vecs[v].id, vecs[v].a, vecs[v].b, rid, rsum, rcarry, lat);
            check("vec_id", rid, vecs[v].id);
            check("vec_sum", rsum, vecs[v].sum);
            check("vec_carry", rcarry, vecs[v].carry);
        end

        // ---- Round-robin with all requesters held valid ----
        grant_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*8 +: 8] = 8'(i * 10 + 1);
            bus.req_b[i*8 +: 8] = 8'(i + 2);
        end
        bus.req_valid = 4'hF;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (grant_q.size() >= 5) break;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 4'h0;
        check("rr_grant_count", grant_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_q.size()) check("rr_order", grant_q[k], exp_order[k]);
        end
        cycles(6);

        // Grant to 1, then a lone request from 3 wins next.
        send_one(1, 8'd3, 8'd3, rid, rsum, rcarry, lat);
        check("rr_pre_id", rid, 1);
        send_one(3, 8'd9, 8'd1, rid, rsum, rcarry, lat);
        check("rr_lone3_id", rid, 3);
        check("rr_lone3_sum", rsum, 10);

        // ---- Backpressure: result held, no grant while in RESP ----
        bus.rsp_ready = 1'b0;
        issue(2, 8'd77, 8'd88);
        wait_rsp(lat);
        bus.req_a[7:0]   = 8'd1;
        bus.req_b[7:0]   = 8'd1;
        bus.req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_rsp_valid", int'(bus.rsp_valid), 1);
            check("bp_rsp_id", int'(bus.rsp_id), 2);
            check("bp_rsp_sum", int'(bus.rsp_sum), 165);
            check("bp_rsp_carry", int'(bus.rsp_carry), 0);
            check("bp_req_ready", int'(bus.req_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_rsp_valid", int'(bus.rsp_valid), 0);
        check("bp_idle_req_ready", int'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        cycles(4);

        // ---- Withdrawn request during RESP: never granted ----
        bus.rsp_ready = 1'b0;
        issue(0, 8'd1, 8'd2);
        wait_rsp(lat);
        grant_q.delete();
        @(posedge clk);
        #1;
        bus.req_a[15:8]  = 8'd50;
        bus.req_b[15:8]  = 8'd60;
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        check("wd_req_ready", int'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        cycles(2);
        bus.rsp_ready = 1'b1;
        cycles(6);
        check("wd_grants", grant_q.size(), 0);
        check("wd_sb_empty", exp_q.size(), 0);

        // ---- Reset asserted mid-RESP drops the in-flight op ----
        bus.rsp_ready = 1'b0;
        issue(1, 8'd5, 8'd6);
        wait_rsp(lat);
        @(posedge clk);
        #1;
        reset_n       = 1'b0;
        bus.req_valid = 4'hF;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
            check("mid_rst_req_ready", int'(bus.req_ready), 0);
            check("mid_rst_rr_ptr", int'(dut.rr_ptr_reg), 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 4'h0;
        reset_n       = 1'b1;
        bus.rsp_ready = 1'b1;
        cycles(1);
        send_one(2, 8'd4, 8'd7, rid, rsum, rcarry, lat);
        check("post_rst_id", rid, 2);
        check("post_rst_sum", rsum, 11);
        check("post_rst_carry", rcarry, 0);

        cycles(4);
        check("final_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
